dc_video_tx: RTL and testbench

- Transmit side of the Dreamcast 12-bit digital video bus.
- Serialises a 24-bit RGB pixel stream onto the 2-clock-per-pixel bus format with active-low _hsync/_vsync, using the raw timing the capture path expects (1716 x 525 clocks/lines, progressive VGA mode).
- Used in board bring-up and self-test to loop generated video back into the capture path without a console attached.
- Pixel source is a ready/valid stream buffered in a small FIFO.

---
 rtl/dc_video_tx_if.sv | 11 +
 rtl/dc_video_tx.sv | 171 +++++++++++++++++
 tb/tb_dc_video_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dc_video_tx_if.sv
// Pixel stream into the Dreamcast video transmitter: 24-bit RGB with start-of-frame flag,
// ready/valid handshake.
interface dc_video_tx_if;
  logic [23:0] in_rgb;
  logic        in_sof;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_rgb, output in_sof, output in_valid, input  in_ready);
  modport slave  (input  in_rgb, input  in_sof, input  in_valid, output in_ready);
endinterface

// File: rtl/dc_video_tx.sv
// Dreamcast 12-bit digital video bus transmitter: raster timing, two-clock-per-pixel
// serialisation from a small pixel FIFO, plus sticky underflow / sof-alignment status.
module dc_video_tx #(
  parameter int unsigned H_TOTAL      = 1716,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned H_SYNC_LEN   = 128,
  parameter int unsigned V_SYNC_LINES = 6,
  parameter int unsigned HSTART       = 265,
  parameter int unsigned VSTART       = 40,
  parameter int unsigned ACTIVE_W     = 640,
  parameter int unsigned ACTIVE_H     = 480,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  dc_video_tx_if.slave       pix,
  output logic [11:0]        data,
  output logic               _hsync,
  output logic               _vsync,
  input  logic               clear_status,
  output logic               underflow,
  output logic [15:0]        underflow_count,
  output logic               sof_error
);

  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C = HW'(H_SYNC_LEN);
  localparam logic [HW-1:0] H_BEG    = HW'(HSTART);
  localparam logic [HW-1:0] H_END    = HW'(HSTART + 2 * ACTIVE_W);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C = VW'(V_SYNC_LINES);
  localparam logic [VW-1:0] V_BEG    = VW'(VSTART);
  localparam logic [VW-1:0] V_END    = VW'(VSTART + ACTIVE_H);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic [11:0]   data_q, data_d, hold_q, hold_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          uf_q, uf_d, sofe_q, sofe_d;
  logic [15:0]   ufc_q, ufc_d;

  logic [24:0]   head;
  logic          empty, active, phase0, first_slot;
  logic          push, pop, uf_evt, sof_evt;

  always_comb begin
    head       = mem_q[rd_q];
    empty      = (cnt_q == '0);
    active     = enable && (v_q >= V_BEG) && (v_q < V_END) && (h_q >= H_BEG) && (h_q < H_END);
    phase0     = (h_q[0] == H_BEG[0]);
    first_slot = (h_q == H_BEG) && (v_q == V_BEG);
    push       = enable && pix.in_valid && rdy_q;
    pop        = active && phase0 && !empty;
    uf_evt     = active && phase0 && empty;
    sof_evt    = pop && (head[24] != first_slot);
  end

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (enable) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
        v_d = v_q;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (AW + 1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW + 1)'(1);
    // in_ready is registered, so it is precomputed from the post-edge occupancy.
    rdy_d = enable && (cnt_d != DEPTH_C);
  end

  always_comb begin
    hs_d   = 1'b1;
    vs_d   = 1'b1;
    data_d = 12'hFFF;
    hold_d = hold_q;
    if (enable) begin
      hs_d   = (h_q >= H_SYNC_C);
      vs_d   = (v_q >= V_SYNC_C);
      data_d = '0;
      if (active) begin
        if (phase0) begin
          // A starved slot loads zero so its second half also goes out blank.
          data_d = pop ? head[23:12] : '0;
          hold_d = pop ? head[11:0]  : '0;
        end else begin
          data_d = hold_q;
        end
      end
    end
  end

  always_comb begin
    uf_d   = (uf_q   && !clear_status) || uf_evt;
    sofe_d = (sofe_q && !clear_status) || sof_evt;
    ufc_d  = clear_status ? '0 : ufc_q;
    if (uf_evt) begin
      if (clear_status)         ufc_d = 16'd1;
      else if (ufc_q != '1)     ufc_d = ufc_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= {pix.in_sof, pix.in_rgb};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_q    <= '0;
      v_q    <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
      data_q <= 12'hFFF;
      hold_q <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      uf_q   <= 1'b0;
      ufc_q  <= '0;
      sofe_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      rdy_q  <= rdy_d;
      data_q <= data_d;
      hold_q <= hold_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      uf_q   <= uf_d;
      ufc_q  <= ufc_d;
      sofe_q <= sofe_d;
      if (!enable) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (pop)  rd_q <= rd_q + AW'(1);
        if (push) wr_q <= wr_q + AW'(1);
        cnt_q <= cnt_d;
      end
    end
  end

  assign pix.in_ready    = rdy_q;
  assign data            = data_q;
  assign _hsync          = hs_q;
  assign _vsync          = vs_q;
  assign underflow       = uf_q;
  assign underflow_count = ufc_q;
  assign sof_error       = sofe_q;

endmodule

// File: tb/tb_dc_video_tx.sv
// Directed bench for dc_video_tx using a reduced raster (40 x 10, active 16 x 4 from (10,3)).
module tb_dc_video_tx;
  localparam int HT = 40, VT = 10, HS = 4, VS = 2, HST = 10, VST = 3, AWID = 8, AHGT = 4;

  logic        clock, reset, enable, clear_status;
  logic [11:0] data;
  logic        hs_n, vs_n, underflow, sof_error;
  logic [15:0] underflow_count;

  dc_video_tx_if pif ();

  dc_video_tx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_LEN(HS), .V_SYNC_LINES(VS),
    .HSTART(HST), .VSTART(VST), .ACTIVE_W(AWID), .ACTIVE_H(AHGT), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .pix(pif),
    .data(data), ._hsync(hs_n), ._vsync(vs_n), .clear_status(clear_status),
    .underflow(underflow), .underflow_count(underflow_count), .sof_error(sof_error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  logic [24:0] src_q[$];
  int oh = 0, ov = 0, th = 0, tv = 0;
  logic oen = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pixel producer: handshake judged on pre-edge values, next item presented #1 later.
  initial begin
    pif.in_valid = 1'b0;
    pif.in_rgb   = '0;
    pif.in_sof   = 1'b0;
    forever begin
      @(posedge clock);
      if (pif.in_valid && pif.in_ready && enable && reset) begin
        src_q.delete(0);
        acc_cnt++;
      end
      #1;
      if (src_q.size() > 0) begin
        pif.in_valid = 1'b1;
        {pif.in_sof, pif.in_rgb} = src_q[0];
      end else begin
        pif.in_valid = 1'b0;
      end
    end
  end

  // Raster position shown on the outputs after each edge.
  initial begin
    forever begin
      @(posedge clock);
      if (!reset || !enable) begin
        th = 0; tv = 0; oen = 1'b0;
      end else begin
        oh = th; ov = tv; oen = 1'b1;
        if (th == HT - 1) begin
          th = 0;
          tv = (tv == VT - 1) ? 0 : tv + 1;
        end else th = th + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

  task automatic wait_out(input int h, input int v);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(oen && oh == h && ov == v) && n < 2000);
    if (!(oen && oh == h && ov == v)) begin
      n_checks++; n_fail++;
      $display("FAIL wait_out: position (%0d,%0d) not reached in %0d clocks, required reached", h, v, n);
    end
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    @(posedge clock);
    #1 clear_status = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; clear_status = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (data !== 12'hFFF) begin n_fail++; $display("FAIL rst_data: got %h need fff", data); end
    n_checks++; if (hs_n !== 1'b1 || vs_n !== 1'b1) begin n_fail++; $display("FAIL rst_sync: got %b%b need 11", hs_n, vs_n); end
    n_checks++; if (pif.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b need 0", pif.in_ready); end
    n_checks++; if (underflow !== 1'b0 || underflow_count !== 16'd0 || sof_error !== 1'b0) begin
      n_fail++; $display("FAIL rst_status: got %b/%0d/%b need 0/0/0", underflow, underflow_count, sof_error); end
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (hs_n !== 1'b0 || vs_n !== 1'b0) begin n_fail++; $display("FAIL first_sync: got %b%b need 00", hs_n, vs_n); end
    n_checks++; if (data !== 12'h000) begin n_fail++; $display("FAIL first_data: got %h need 000", data); end
    n_checks++; if (pif.in_ready !== 1'b1) begin n_fail++; $display("FAIL first_ready: got %b need 1", pif.in_ready); end
  endtask

  task automatic test_sync_timing();
    int hs_low = 0, vs_low = 0, hr1 = -1, hr2 = -1, vr = -1;
    logic phs, pvs;
    phs = hs_n; pvs = vs_n;
    for (int i = 0; i < HT * VT; i++) begin
      if (hs_n === 1'b0) hs_low++;
      if (vs_n === 1'b0) vs_low++;
      if (phs === 1'b0 && hs_n === 1'b1) begin if (hr1 < 0) hr1 = i; else if (hr2 < 0) hr2 = i; end
      if (pvs === 1'b0 && vs_n === 1'b1 && vr < 0) vr = i;
      phs = hs_n; pvs = vs_n;
      @(negedge clock);
    end
    n_checks++; if (hs_low != 40) begin n_fail++; $display("FAIL hs_low: got %0d need 40", hs_low); end
    n_checks++; if (vs_low != 80) begin n_fail++; $display("FAIL vs_low: got %0d need 80", vs_low); end
    n_checks++; if (hr1 != 4) begin n_fail++; $display("FAIL hs_rise: got %0d need 4", hr1); end
    n_checks++; if (hr2 - hr1 != 40) begin n_fail++; $display("FAIL hs_period: got %0d need 40", hr2 - hr1); end
    n_checks++; if (vr != 80) begin n_fail++; $display("FAIL vs_rise: got %0d need 80", vr); end
  endtask

  task automatic test_pixel();
    src_q.push_back({1'b1, 24'hA5C33C});
    for (int k = 1; k < AWID; k++) src_q.push_back({1'b0, 8'(8'h20 + k), 8'h11, 8'h22});
    pulse_clear();
    n_checks++; if (underflow !== 1'b0 || underflow_count !== 16'd0) begin
      n_fail++; $display("FAIL clr_uf: got %b/%0d need 0/0", underflow, underflow_count); end
    wait_out(10, 3);
    n_checks++; if (data !== 12'hA5C) begin n_fail++; $display("FAIL px_ph0: got %h need a5c", data); end
    @(negedge clock);
    n_checks++; if (data !== 12'h33C) begin n_fail++; $display("FAIL px_ph1: got %h need 33c", data); end
    wait_out(26, 3);
    n_checks++; if (data !== 12'h000) begin n_fail++; $display("FAIL px_after: got %h need 000", data); end
    n_checks++; if (underflow !== 1'b0 || sof_error !== 1'b0) begin
      n_fail++; $display("FAIL px_flags: got uf=%b sof=%b need 0 0", underflow, sof_error); end
  endtask

  task automatic test_underflow();
    wait_out(0, 1);
    pulse_clear();
    n_checks++; if (underflow_count !== 16'd0 || sof_error !== 1'b0) begin
      n_fail++; $display("FAIL uf_clr: got %0d/%b need 0/0", underflow_count, sof_error); end
    for (int k = 0; k < AWID - 1; k++) src_q.push_back({(k == 0), 8'(8'h10 + k), 8'hC3, 8'(8'h3C + k)});
    wait_out(22, 3);
    n_checks++; if (data !== 12'h16C) begin n_fail++; $display("FAIL uf_s6a: got %h need 16c", data); end
    @(negedge clock);
    n_checks++; if (data !== 12'h342) begin n_fail++; $display("FAIL uf_s6b: got %h need 342", data); end
    @(negedge clock);
    n_checks++; if (data !== 12'h000) begin n_fail++; $display("FAIL uf_s7a: got %h need 000", data); end
    n_checks++; if (underflow !== 1'b1 || underflow_count !== 16'd1) begin
      n_fail++; $display("FAIL uf_flag: got %b/%0d need 1/1", underflow, underflow_count); end
    @(negedge clock);
    n_checks++; if (data !== 12'h000) begin n_fail++; $display("FAIL uf_s7b: got %h need 000", data); end
    @(negedge clock);
    for (int k = 0; k < AWID; k++) src_q.push_back({1'b0, 8'(8'h80 + k), 8'h7E, 8'(8'h01 + k)});
    wait_out(10, 4);
    n_checks++; if (data !== 12'h807) begin n_fail++; $display("FAIL l4_s0a: got %h need 807", data); end
    @(negedge clock);
    n_checks++; if (data !== 12'hE01) begin n_fail++; $display("FAIL l4_s0b: got %h need e01", data); end
    wait_out(24, 4);
    n_checks++; if (data !== 12'h877) begin n_fail++; $display("FAIL l4_s7a: got %h need 877", data); end
    @(negedge clock);
    n_checks++; if (data !== 12'hE08) begin n_fail++; $display("FAIL l4_s7b: got %h need e08", data); end
    n_checks++; if (underflow_count !== 16'd1 || sof_error !== 1'b0) begin
      n_fail++; $display("FAIL l4_status: got %0d/%b need 1/0", underflow_count, sof_error); end
  endtask

  task automatic test_back_to_back();
    int acc0;
    wait_out(0, 0);
    acc0 = acc_cnt;
    for (int k = 0; k < 6; k++) src_q.push_back({(k == 0), 8'(8'hB0 + k), 8'hD2, 8'(8'hE0 + k)});
    repeat (12) @(negedge clock);
    n_checks++; if (acc_cnt - acc0 != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d need 4", acc_cnt - acc0); end
    n_checks++; if (pif.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b need 0", pif.in_ready); end
    n_checks++; if (src_q.size() != 2) begin n_fail++; $display("FAIL bp_pending: got %0d need 2", src_q.size()); end
    wait_out(10, 3);
    n_checks++; if (data !== 12'hB0D) begin n_fail++; $display("FAIL bp_s0a: got %h need b0d", data); end
    @(negedge clock);
    n_checks++; if (data !== 12'h2E0) begin n_fail++; $display("FAIL bp_s0b: got %h need 2e0", data); end
    wait_out(16, 3);
    n_checks++; if (data !== 12'hB3D) begin n_fail++; $display("FAIL bp_s3a: got %h need b3d", data); end
    wait_out(18, 3);
    n_checks++; if (data !== 12'hB4D) begin n_fail++; $display("FAIL bp_s4a: got %h need b4d", data); end
    wait_out(21, 3);
    n_checks++; if (data !== 12'h2E5) begin n_fail++; $display("FAIL bp_s5b: got %h need 2e5", data); end
    n_checks++; if (acc_cnt - acc0 != 6 || sof_error !== 1'b0) begin
      n_fail++; $display("FAIL bp_total: got %0d sof=%b need 6 0", acc_cnt - acc0, sof_error); end
  endtask

  task automatic test_enable();
    wait_out(0, 1);
    src_q.push_back({1'b1, 24'h777777});
    src_q.push_back({1'b0, 24'h777777});
    wait_out(29, 1);
    enable = 1'b0;
    @(negedge clock);
    n_checks++; if (data !== 12'hFFF || hs_n !== 1'b1 || vs_n !== 1'b1) begin
      n_fail++; $display("FAIL dis_idle: got %h %b%b need fff 11", data, hs_n, vs_n); end
    n_checks++; if (pif.in_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready: got %b need 0", pif.in_ready); end
    pulse_clear();
    repeat (3) @(negedge clock);
    n_checks++; if (data !== 12'hFFF) begin n_fail++; $display("FAIL dis_hold: got %h need fff", data); end
    enable = 1'b1;
    @(negedge clock);
    n_checks++; if (hs_n !== 1'b0 || vs_n !== 1'b0 || data !== 12'h000) begin
      n_fail++; $display("FAIL reen_first: got %b%b %h need 00 000", hs_n, vs_n, data); end
    repeat (3) @(negedge clock);
    n_checks++; if (hs_n !== 1'b0) begin n_fail++; $display("FAIL reen_h3: got %b need 0", hs_n); end
    @(negedge clock);
    n_checks++; if (hs_n !== 1'b1) begin n_fail++; $display("FAIL reen_h4: got %b need 1", hs_n); end
    wait_out(10, 3);
    n_checks++; if (data !== 12'h000 || underflow !== 1'b1 || underflow_count !== 16'd1) begin
      n_fail++; $display("FAIL flush: got %h %b/%0d need 000 1/1", data, underflow, underflow_count); end
  endtask

  task automatic test_sof_error();
    wait_out(0, 0);
    for (int k = 0; k < AWID; k++) src_q.push_back({(k == 0 || k == 5), 8'(8'h40 + k), 8'h99, 8'(8'h01 + k)});
    wait_out(19, 3);
    n_checks++; if (sof_error !== 1'b0) begin n_fail++; $display("FAIL sof_before: got %b need 0", sof_error); end
    @(negedge clock);
    n_checks++; if (sof_error !== 1'b1) begin n_fail++; $display("FAIL sof_set: got %b need 1", sof_error); end
    n_checks++; if (data !== 12'h459) begin n_fail++; $display("FAIL sof_px_a: got %h need 459", data); end
    @(negedge clock);
    n_checks++; if (data !== 12'h906) begin n_fail++; $display("FAIL sof_px_b: got %h need 906", data); end
    wait_out(27, 3);
    pulse_clear();
    n_checks++; if (sof_error !== 1'b0 || underflow !== 1'b0 || underflow_count !== 16'd0) begin
      n_fail++; $display("FAIL clr_all: got %b %b/%0d need 0 0/0", sof_error, underflow, underflow_count); end
    wait_out(9, 4);
    clear_status = 1'b1;
    @(negedge clock);
    clear_status = 1'b0;
    n_checks++; if (underflow !== 1'b1 || underflow_count !== 16'd1) begin
      n_fail++; $display("FAIL clr_vs_evt: got %b/%0d need 1/1", underflow, underflow_count); end
    repeat (2) @(negedge clock);
    n_checks++; if (underflow_count !== 16'd2) begin n_fail++; $display("FAIL uf_count2: got %0d need 2", underflow_count); end
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_pixel();
    test_underflow();
    test_back_to_back();
    test_enable();
    test_sof_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
